// File: rtl/mem_write_drain_pkg.sv
// Purpose: shared types and default widths for the write-buffer drain path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_write_drain_pkg;

    localparam int MEM_ADDRESS_WIDTH = 32;
    localparam int MEM_DATA_WIDTH    = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        REQ     = 2'd3
    } drain_state_t;

endpackage

// File: rtl/mem_drain_watchdog.sv
// Purpose: counts cycles spent waiting for a memory ack and flags a stuck request.
// Latency: expired is combinational from the count; counter restarts at 0 on each REQ entry.
// Backpressure: none; an ack in the limit cycle suppresses expired.
// Ports: clk, rst_n (async, active-low), enable (controller in REQ), ack, expired (pulse).
module mem_drain_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    assign expired = enable && !ack && (cnt == LIMIT);

    // Held at zero outside REQ so every request starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_write_drain.sv
// Purpose: pops {address,data} entries from the write buffer and issues each as one memory write; runs the flush handshake.
// Latency: rd_en pulse in cycle t, mem_req_o visible in t+2; at most one write per 4 cycles.
// Backpressure: mem_req_o and address/data are held until mem_ack_i; the FIFO is only popped from IDLE.
// Ports: fifo_* (read side of fifo_address_data), mem_* (write req/ack), flush_i/flush_done_o, busy_o, err_timeout_o.
// Build option: define MEM_WRITE_DRAIN_TIMEOUT_EN to enable the ack watchdog; otherwise err_timeout_o is tied low.
module mem_write_drain
    import mem_write_drain_pkg::*;
#(
    parameter int ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = MEM_DATA_WIDTH,
    parameter int TIMEOUT       = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rd_en_o,
    input  logic [ADDRESS_WIDTH-1:0] fifo_address_i,
    input  logic [DATA_WIDTH-1:0]    fifo_data_i,
    output logic                     mem_req_o,
    output logic [ADDRESS_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0]    mem_data_o,
    input  logic                     mem_ack_i,
    input  logic                     flush_i,
    output logic                     flush_done_o,
    output logic                     busy_o,
    output logic                     err_timeout_o
);

    drain_state_t state;
    drain_state_t state_next;
    logic         flush_pend;
    logic         flush_fire;
    logic         timeout_hit;

`ifdef MEM_WRITE_DRAIN_TIMEOUT_EN
    mem_drain_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state == REQ),
        .ack     (mem_ack_i),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout_o <= 1'b0;
        end else if (timeout_hit) begin
            err_timeout_o <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg    = (TIMEOUT < 2);
    assign timeout_hit   = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    assign busy_o = (state != IDLE);

    // Empty is only trusted in IDLE, which is at least 3 cycles after the
    // last pop and so past the FIFO's two-cycle empty update lag.
    // A flush_i arriving while IDLE with an empty FIFO completes at once.
    always_comb begin
        state_next = state;
        flush_fire = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty_i) begin
                    state_next = POP;
                end else begin
                    flush_fire = flush_pend || flush_i;
                end
            end
            POP:     state_next = CAPTURE;
            CAPTURE: state_next = REQ;
            REQ: begin
                if (mem_ack_i || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fifo_rd_en_o  <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_address_o <= '0;
            mem_data_o    <= '0;
            flush_pend    <= 1'b0;
            flush_done_o  <= 1'b0;
        end else begin
            state        <= state_next;
            fifo_rd_en_o <= (state_next == POP);
            mem_req_o    <= (state_next == REQ);
            flush_done_o <= flush_fire;
            // FIFO read data is valid the cycle after the pop.
            if (state == CAPTURE) begin
                mem_address_o <= fifo_address_i;
                mem_data_o    <= fifo_data_i;
            end
            if (flush_fire) begin
                flush_pend <= 1'b0;
            end else if (flush_i) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_drain.sv
module tb_mem_write_drain;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty_i = 1'b1;
    logic          fifo_rd_en_o;
    logic [AW-1:0] fifo_address_i = '0;
    logic [DW-1:0] fifo_data_i = '0;
    logic          mem_req_o;
    logic [AW-1:0] mem_address_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ack_i = 1'b0;
    logic          flush_i;
    logic          flush_done_o;
    logic          busy_o;
    logic          err_timeout_o;

    mem_write_drain #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT       (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .fifo_address_i (fifo_address_i),
        .fifo_data_i    (fifo_data_i),
        .mem_req_o      (mem_req_o),
        .mem_address_o  (mem_address_o),
        .mem_data_o     (mem_data_o),
        .mem_ack_i      (mem_ack_i),
        .flush_i        (flush_i),
        .flush_done_o   (flush_done_o),
        .busy_o         (busy_o),
        .err_timeout_o  (err_timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Stimulus-side shared state
    entry_t fifo_q[$];
    entry_t exp_q[$];
    int     ack_wait = 1;
    bit     b2b = 1'b0;
    int     discard_req = 0;

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        entry_t e;
        e.a = a;
        e.d = d;
        fifo_q.push_back(e);
        exp_q.push_back(e);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Write-buffer FIFO model: one-cycle read latency, empty lags the contents by two edges.
    logic empty_d1 = 1'b1;
    always @(posedge clk) begin
        if (fifo_rd_en_o) begin
            check_eq("pop_nonempty", 128'(fifo_q.size() != 0), 128'd1);
            if (fifo_q.size() != 0) begin
                fifo_address_i <= fifo_q[0].a;
                fifo_data_i    <= fifo_q[0].d;
                void'(fifo_q.pop_front());
            end
        end
        empty_d1     <= (fifo_q.size() == 0);
        fifo_empty_i <= empty_d1;
    end

    // Memory responder: ack in the ack_wait-th cycle of each request.
    int rcnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n || !mem_req_o) begin
            rcnt = 0;
            mem_ack_i = 1'b0;
        end else begin
            mem_ack_i = (rcnt == ack_wait - 1);
            rcnt++;
        end
    end

    // Monitor / scoreboard
    int req_len = 0;
    int last_pop_cyc = -100;
    int prev_start = 0;
    bit have_prev = 1'b0;
    bit rd_prev = 1'b0;
    int pops = 0;
    int writes = 0;
    int timeouts = 0;
    int done_cnt = 0;
    int discard_done = 0;

    always @(negedge clk) begin
        entry_t e;
        if (discard_req != discard_done) begin
            void'(exp_q.pop_front());
            discard_done++;
        end
        if (!rst_n) begin
            req_len = 0;
            rd_prev = 1'b0;
            have_prev = 1'b0;
        end else begin
            if (fifo_rd_en_o) begin
                check_eq("rd_en_single_cycle", 128'(rd_prev), 128'd0);
                pops++;
                last_pop_cyc = cyc;
            end
            rd_prev = fifo_rd_en_o;
            if (!b2b) have_prev = 1'b0;
            if (flush_done_o) begin
                done_cnt++;
                check_eq("flush_after_writes", 128'(exp_q.size()), 128'd0);
            end
            if (mem_req_o) begin
                if (req_len == 0) begin
                    check_eq("pop_to_req", 128'(cyc - last_pop_cyc), 128'd2);
                    check_eq("busy_in_req", 128'(busy_o), 128'd1);
                    if (have_prev) check_eq("b2b_spacing", 128'(cyc - prev_start), 128'd4);
                    prev_start = cyc;
                    have_prev = b2b;
                end
                req_len++;
                if (mem_ack_i) begin
                    check_eq("write_expected", 128'(exp_q.size() != 0), 128'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("mem_address", 128'(mem_address_o), 128'(e.a));
                        check_eq("mem_data", mem_data_o, e.d);
                    end
                    check_eq("req_length", 128'(req_len), 128'(ack_wait));
                    writes++;
                    req_len = 0;
                end
            end else if (req_len != 0) begin
`ifdef MEM_WRITE_DRAIN_TIMEOUT_EN
                check_eq("timeout_req_length", 128'(req_len), 128'(TO));
                check_eq("timeout_err_set", 128'(err_timeout_o), 128'd1);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                timeouts++;
`else
                check_eq("req_dropped_without_ack", 128'(req_len), 128'd0);
`endif
                req_len = 0;
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy_o) && n < limit);
        check_eq("drain_in_time", 128'(n < limit), 128'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        int w0;
        int d0;
        rst_n = 1'b0;
        flush_i = 1'b0;

        // Reset with the FIFO non-empty
        push(32'h0000_0100, {4{32'hA5A5_0001}});
        repeat (4) begin
            @(negedge clk);
            check_eq("reset_rd_en", 128'(fifo_rd_en_o), 128'd0);
        end
        check_eq("reset_ctrl_outs", 128'({mem_req_o, flush_done_o, busy_o, err_timeout_o}), 128'd0);
        check_eq("reset_address", 128'(mem_address_o), 128'd0);
        check_eq("reset_data", mem_data_o, 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_pop_early", 128'(fifo_rd_en_o), 128'd0);
        @(negedge clk);
        check_eq("first_pop", 128'(fifo_rd_en_o), 128'd1);
        wait_idle(100);

        // Single write, ack in the third request cycle
        ack_wait = 3;
        p0 = pops;
        push(32'h0000_1000, {4{32'hDEAD_BEEF}});
        wait_idle(100);
        check_eq("single_pop_count", 128'(pops - p0), 128'd1);

        // Back-to-back with immediate ack
        ack_wait = 1;
        b2b = 1'b1;
        p0 = pops;
        w0 = writes;
        for (int i = 0; i < 4; i++) push(32'h0000_2000 + 32'(i * 16), {4{32'(i) + 32'h1111_0000}});
        wait_idle(100);
        b2b = 1'b0;
        check_eq("b2b_writes", 128'(writes - w0), 128'd4);
        check_eq("b2b_pops", 128'(pops - p0), 128'd4);

        // Flush with two entries queued
        ack_wait = 2;
        d0 = done_cnt;
        push(32'h0000_3000, {4{32'h3333_0000}});
        push(32'h0000_3010, {4{32'h3333_0001}});
        n = 0;
        while (!busy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("flush_busy_seen", 128'(busy_o), 128'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        wait_idle(100);
        repeat (3) @(negedge clk);
        check_eq("flush_done_once", 128'(done_cnt - d0), 128'd1);

        // Flush while idle and empty; re-flush in the done cycle
        d0 = done_cnt;
        @(negedge clk);
        check_eq("flush_idle_before", 128'(flush_done_o), 128'd0);
        flush_i = 1'b1;
        @(negedge clk);
        check_eq("flush_idle_latency", 128'(flush_done_o), 128'd1);
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("flush_reassert", 128'(flush_done_o), 128'd1);
        @(negedge clk);
        check_eq("flush_single_cycle", 128'(flush_done_o), 128'd0);
        check_eq("flush_idle_count", 128'(done_cnt - d0), 128'd2);

        // Async reset while a request is outstanding
        ack_wait = 50;
        push(32'h0000_4000, {4{32'h4444_4444}});
        n = 0;
        while (!mem_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_req_seen", 128'(mem_req_o), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset_req", 128'(mem_req_o), 128'd0);
        check_eq("async_reset_busy", 128'(busy_o), 128'd0);
        discard_req++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_wait = 1;
        w0 = writes;
        push(32'h0000_5000, {4{32'h5555_5555}});
        wait_idle(100);
        check_eq("resume_after_reset", 128'(writes - w0), 128'd1);

`ifdef MEM_WRITE_DRAIN_TIMEOUT_EN
        // Watchdog: ack never arrives
        ack_wait = 1000;
        w0 = timeouts;
        push(32'h0000_6000, {4{32'h6666_6666}});
        wait_idle(200);
        check_eq("timeout_count", 128'(timeouts - w0), 128'd1);
        check_eq("timeout_err", 128'(err_timeout_o), 128'd1);
        ack_wait = 1;
        w0 = writes;
        push(32'h0000_7000, {4{32'h7777_7777}});
        wait_idle(100);
        check_eq("drain_after_timeout", 128'(writes - w0), 128'd1);
        check_eq("err_sticky", 128'(err_timeout_o), 128'd1);
`endif

        // Randomized bursts
        for (int b = 0; b < 5; b++) begin
            int cnt;
            ack_wait = int'($urandom_range(1, 4));
            cnt = int'($urandom_range(1, 6));
            w0 = writes;
            for (int k = 0; k < cnt; k++) begin
                push($urandom, {$urandom, $urandom, $urandom, $urandom});
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(300);
            check_eq("random_burst_writes", 128'(writes - w0), 128'(cnt));
        end

`ifndef MEM_WRITE_DRAIN_TIMEOUT_EN
        check_eq("err_tied_low", 128'(err_timeout_o), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_write_drain.md
# mem_write_drain

Drain controller for the write buffer between the data cache and main memory. It pops {address, data} entries from the write-buffer FIFO one at a time and issues each as a single write transaction on the memory request/acknowledge interface. It also runs a flush handshake so the cache can wait until every buffered write has reached memory. It is the read-side consumer of `fifo_address_data`.

## Interface
- `ADDRESS_WIDTH`, 32, width of buffered address.
- `DATA_WIDTH`, 128, width of buffered data line.
- `TIMEOUT`, 256, ack watchdog limit in cycles; must be ≥ 2. Used only with the macro.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fifo_empty_i`  in  1  FIFO `empty`, registered on the FIFO side.
- `fifo_rd_en_o`  out  1  FIFO `rd_en`; a single-cycle pulse per pop.
- `fifo_address_i`  in  ADDRESS_WIDTH  FIFO `address_out`.
- `fifo_data_i`  in  DATA_WIDTH  FIFO `data_out`.
- `mem_req_o`  out  1  memory write request.
- `mem_address_o`  out  ADDRESS_WIDTH  write address.
- `mem_data_o`  out  DATA_WIDTH  write data.
- `mem_ack_i`  in  1  memory acknowledge.
- `flush_i`  in  1  flush request pulse.
- `flush_done_o`  out  1  single-cycle pulse when the flush is complete.
- `busy_o`  out  1  high in any state other than IDLE.
- `err_timeout_o`  out  1  sticky watchdog error.

## Operation
- FSM states: IDLE, POP, CAPTURE, REQ.
- **IDLE**
  - If `fifo_empty_i`=0: go to POP.
  - Else, if a flush is pending: pulse `flush_done_o` and clear the pending flag.
- **POP**
  - Assert `fifo_rd_en_o` for exactly this cycle.
  - Go to CAPTURE.
- **CAPTURE**
  - FIFO output is valid this cycle (one-cycle FIFO read latency).
  - Register `fifo_address_i`/`fifo_data_i` into `mem_address_o`/`mem_data_o`.
  - Set `mem_req_o`=1 and go to REQ.
- **REQ**
  - Hold `mem_req_o` and the address/data stable until `mem_ack_i` is sampled high.
  - On ack: clear `mem_req_o` and go to IDLE.
- **Empty sampling:** `fifo_empty_i` is sampled only in IDLE. IDLE is always ≥3 cycles after the last pop, which covers the FIFO's two-cycle lag between pop and an updated `empty`. The controller never issues a pop based on a stale `empty`.
- **Flush pending flag**
  - Set by `flush_i`=1 in any state.
  - `flush_i` asserted in the same cycle as `flush_done_o` keeps the flag set; the flush completes at the next empty IDLE.
- **Buffered data:** `mem_address_o`/`mem_data_o` keep their last value after ack. They are meaningful only while `mem_req_o`=1.
- **Reset:** asserting `rst_n` at any time, including mid-transaction, forces the following. The in-flight entry is lost.
  - State returns to IDLE.
  - `mem_req_o` and `fifo_rd_en_o` go to 0.
  - The flush pending flag is cleared.

## Timing
- Reset values: all outputs are 0, including `mem_address_o`, `mem_data_o` and `err_timeout_o`.
- Pop to request latency:
  - `fifo_rd_en_o` is high in cycle t.
  - `mem_req_o` rises at the t+1 edge and is first visible in cycle t+2.
- Minimum transaction: ack is sampled in the first REQ cycle, so `mem_req_o` is high for exactly 1 cycle.
- Throughput: at most one write per 4 cycles (IDLE, POP, CAPTURE, REQ).
- `flush_done_o`:
  - Registered; high for one cycle.
  - Earliest: 1 cycle after `flush_i` when the controller is in IDLE with an empty FIFO.

## Configuration
- Macro: `MEM_WRITE_DRAIN_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in REQ, starting from 0 on entry.
  - If it reaches `TIMEOUT`-1 with no ack:
    - `err_timeout_o` sets and stays set until reset.
    - `mem_req_o` drops and the entry is discarded.
    - The FSM goes to IDLE.
  - An ack in the same cycle as the limit wins: normal completion, no error.
- **Undefined:** REQ waits for ack indefinitely; `err_timeout_o` is tied to 0. The port exists in both builds.

## Structure
- Shared memory package holds:
  - typedef `drain_state_t` (enum IDLE/POP/CAPTURE/REQ);
  - default width constants `MEM_ADDRESS_WIDTH`, `MEM_DATA_WIDTH`.
- Sub-module `mem_drain_watchdog`:
  - ports: clk, rst_n, enable (state==REQ), ack, expired pulse;
  - parameter `TIMEOUT`; counter width `$clog2(TIMEOUT)`;
  - instantiated only under the macro.

## Test plan
- **Reset:** FIFO held non-empty during reset → no `fifo_rd_en_o`, all outputs 0; first pop one cycle after IDLE samples non-empty.
- **Single write:** one entry {0x0000_1000, 0xDEADBEEF...} in the FIFO, ack 3 cycles after req → `mem_req_o` high 3 cycles with exactly that address/data; exactly one `fifo_rd_en_o` pulse.
- **Back-to-back:** 4 entries, ack immediate → 4 writes in order, each `mem_req_o` high 1 cycle; write starts spaced 4 cycles apart; no extra pop after the FIFO reports empty.
- **Flush:** `flush_i` pulsed with 2 entries queued → `flush_done_o` pulses once, after the second ack; a flush with an empty FIFO and the controller in IDLE → `flush_done_o` one cycle later.
- **Async reset mid-REQ:** `rst_n` low while `mem_req_o`=1 → `mem_req_o` goes to 0 immediately (asynchronously, before the next edge); resumes from IDLE after release.
- **Watchdog (macro defined, `TIMEOUT`=8):** ack never given → after 8 cycles in REQ `mem_req_o` drops and `err_timeout_o`=1 sticky; the next entry is still drained normally.
